// File: rtl/mult_div_unit.sv
`default_nettype none
// ============================================================================
// Module   : mult_div_unit
// Brief    : Iterative 32-bit signed multiply / restoring divide, 32-cycle op.
// Revision : 1.0
// ============================================================================
module mult_div_unit (
    input  logic        clk,
    input  logic        reset,
    input  logic        start,
    input  logic        DivOrM,
    input  logic [31:0] a,
    input  logic [31:0] b,
    output logic [31:0] hi,
    output logic [31:0] lo,
    output logic        busy,
    output logic        done,
    output logic        DivZero
);

    localparam logic [5:0] c_LAST_ITER = 6'd31;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CALC = 2'd1,
        DONE = 2'd2,
        ZERO = 2'd3
    } state_t;

    state_t      state_q;
    logic [5:0]  iter_q;
    logic        op_div_q;
    logic        neg_res_q;
    logic        neg_rem_q;
    logic [31:0] opnd_q;
    logic [63:0] acc_q;
    logic [31:0] hi_q;
    logic [31:0] lo_q;
    logic        busy_q;
    logic        done_q;
    logic        divzero_q;

    logic [31:0] abs_a_d;
    logic [31:0] abs_b_d;
    logic [32:0] add_sum_d;
    logic [32:0] rem_shift_d;
    logic [32:0] rem_sub_d;
    logic        rem_ge_d;
    logic [63:0] acc_d;
    logic [63:0] prod_d;
    logic [31:0] quo_d;
    logic [31:0] rem_d;
    logic [31:0] hi_d;
    logic [31:0] lo_d;

    // acc_q holds {partial product, multiplier} or {remainder, dividend/quotient};
    // both shift one bit per iteration so a single register serves either op.
    always_comb begin
        abs_a_d     = a[31] ? (~a + 32'd1) : a;
        abs_b_d     = b[31] ? (~b + 32'd1) : b;
        add_sum_d   = {1'b0, acc_q[63:32]} + (acc_q[0] ? {1'b0, opnd_q} : 33'd0);
        rem_shift_d = {acc_q[63:32], acc_q[31]};
        rem_sub_d   = rem_shift_d - {1'b0, opnd_q};
        rem_ge_d    = ~rem_sub_d[32];
        if (op_div_q) begin
            acc_d = {(rem_ge_d ? rem_sub_d[31:0] : rem_shift_d[31:0]),
                     acc_q[30:0], rem_ge_d};
        end else begin
            acc_d = {add_sum_d, acc_q[31:1]};
        end
        prod_d = neg_res_q ? (~acc_d + 64'd1) : acc_d;
        quo_d  = neg_res_q ? (~acc_d[31:0] + 32'd1) : acc_d[31:0];
        rem_d  = neg_rem_q ? (~acc_d[63:32] + 32'd1) : acc_d[63:32];
        hi_d   = op_div_q ? rem_d : prod_d[63:32];
        lo_d   = op_div_q ? quo_d : prod_d[31:0];
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            state_q   <= IDLE;
            iter_q    <= 6'd0;
            op_div_q  <= 1'b0;
            neg_res_q <= 1'b0;
            neg_rem_q <= 1'b0;
            opnd_q    <= 32'd0;
            acc_q     <= 64'd0;
            hi_q      <= 32'd0;
            lo_q      <= 32'd0;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
            divzero_q <= 1'b0;
        end else begin
            case (state_q)
                IDLE: begin
                    done_q    <= 1'b0;
                    divzero_q <= 1'b0;
                    if (start) begin
                        iter_q <= 6'd0;
                        busy_q <= 1'b1;
                        if (DivOrM && (b == 32'd0)) begin
                            state_q   <= ZERO;
                            divzero_q <= 1'b1;
                        end else begin
                            state_q   <= CALC;
                            op_div_q  <= DivOrM;
                            neg_res_q <= a[31] ^ b[31];
                            neg_rem_q <= a[31];
                            opnd_q    <= DivOrM ? abs_b_d : abs_a_d;
                            acc_q     <= {32'd0, (DivOrM ? abs_a_d : abs_b_d)};
                        end
                    end
                end
                CALC: begin
                    acc_q  <= acc_d;
                    iter_q <= iter_q + 6'd1;
                    if (iter_q == c_LAST_ITER) begin
                        hi_q    <= hi_d;
                        lo_q    <= lo_d;
                        done_q  <= 1'b1;
                        state_q <= DONE;
                    end
                end
                DONE: begin
                    done_q  <= 1'b0;
                    busy_q  <= 1'b0;
                    state_q <= IDLE;
                end
                ZERO: begin
                    divzero_q <= 1'b0;
                    busy_q    <= 1'b0;
                    state_q   <= IDLE;
                end
                default: begin
                    busy_q  <= 1'b0;
                    state_q <= IDLE;
                end
            endcase
        end
    end

    assign hi      = hi_q;
    assign lo      = lo_q;
    assign busy    = busy_q;
    assign done    = done_q;
    assign DivZero = divzero_q;

endmodule
`default_nettype wire

// File: tb/tb_mult_div_unit.sv
`default_nettype none
// ============================================================================
// Module   : tb_mult_div_unit
// Brief    : Directed self-checking bench for mult_div_unit.
// Revision : 1.0
// ============================================================================
module tb_mult_div_unit;

    logic        clk = 1'b0;
    logic        reset;
    logic        start;
    logic        DivOrM;
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] hi;
    logic [31:0] lo;
    logic        busy;
    logic        done;
    logic        DivZero;

    int n_checks = 0;
    int n_fails  = 0;

    mult_div_unit dut (
        .clk     (clk),
        .reset   (reset),
        .start   (start),
        .DivOrM  (DivOrM),
        .a       (a),
        .b       (b),
        .hi      (hi),
        .lo      (lo),
        .busy    (busy),
        .done    (done),
        .DivZero (DivZero)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic        op;
        logic [31:0] av;
        logic [31:0] bv;
        logic [31:0] ehi;
        logic [31:0] elo;
    } vec_t;

    localparam int c_NVEC = 12;

    vec_t vecs [c_NVEC] = '{
        '{1'b0, 32'h0000_0007, 32'hFFFF_FFFD, 32'hFFFF_FFFF, 32'hFFFF_FFEB},
        '{1'b1, 32'hFFFF_FFF9, 32'h0000_0002, 32'hFFFF_FFFF, 32'hFFFF_FFFD},
        '{1'b1, 32'h8000_0000, 32'hFFFF_FFFF, 32'h0000_0000, 32'h8000_0000},
        '{1'b0, 32'h8000_0000, 32'h8000_0000, 32'h4000_0000, 32'h0000_0000},
        '{1'b1, 32'h0000_0064, 32'hFFFF_FFF9, 32'h0000_0002, 32'hFFFF_FFF2},
        '{1'b1, 32'hFFFF_FF9C, 32'h0000_0007, 32'hFFFF_FFFE, 32'hFFFF_FFF2},
        '{1'b0, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'h0000_0000, 32'h0000_0001},
        '{1'b1, 32'h7FFF_FFFF, 32'h8000_0000, 32'h7FFF_FFFF, 32'h0000_0000},
        '{1'b1, 32'h8000_0000, 32'h8000_0000, 32'h0000_0000, 32'h0000_0001},
        '{1'b0, 32'h0000_0000, 32'h1234_5678, 32'h0000_0000, 32'h0000_0000},
        '{1'b1, 32'h0000_0005, 32'h0000_000A, 32'h0000_0005, 32'h0000_0000},
        '{1'b0, 32'h7FFF_FFFF, 32'h7FFF_FFFF, 32'h3FFF_FFFF, 32'h0000_0001}
    };

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fails++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
        end
    endtask

    // Caller is at a negedge with the DUT idle; sample m is the cycle k+m after the start edge.
    task automatic run_op(input logic op, input logic [31:0] av, input logic [31:0] bv,
                          output logic [31:0] r_hi, output logic [31:0] r_lo,
                          output int done_at, output int done_cnt, output int busy_cnt,
                          output int dz_cnt, output int hold_err);
        logic [31:0] hi0;
        logic [31:0] lo0;
        hi0 = hi; lo0 = lo;
        r_hi = '0; r_lo = '0;
        done_at = -1; done_cnt = 0; busy_cnt = 0; dz_cnt = 0; hold_err = 0;
        start = 1'b1; DivOrM = op; a = av; b = bv;
        @(negedge clk);
        start = 1'b0;
        for (int m = 0; m < 40; m++) begin
            if (busy) busy_cnt++;
            if (DivZero) dz_cnt++;
            if (m < 32 && (hi !== hi0 || lo !== lo0)) hold_err++;
            if (done) begin
                done_cnt++;
                done_at = m;
                r_hi = hi;
                r_lo = lo;
            end
            a = $urandom; b = $urandom; DivOrM = ~op;
            @(negedge clk);
        end
    endtask

    initial begin
        #400000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin : main
        logic [31:0] r_hi;
        logic [31:0] r_lo;
        int done_at, done_cnt, busy_cnt, dz_cnt, hold_err;
        int prev, dc, dn, dz;

        reset = 1'b0; start = 1'b1; DivOrM = 1'b0; a = 32'd1; b = 32'd1;
        repeat (3) @(negedge clk);
        check("rst_hi", 64'(hi), 64'h0);
        check("rst_lo", 64'(lo), 64'h0);
        check("rst_busy", 64'(busy), 64'h0);
        check("rst_done", 64'(done), 64'h0);
        check("rst_divzero", 64'(DivZero), 64'h0);
        reset = 1'b1; start = 1'b0;
        @(negedge clk);
        check("rst_idle_busy", 64'(busy), 64'h0);

        for (int i = 0; i < c_NVEC; i++) begin
            run_op(vecs[i].op, vecs[i].av, vecs[i].bv, r_hi, r_lo,
                   done_at, done_cnt, busy_cnt, dz_cnt, hold_err);
            check($sformatf("v%0d_hi", i), 64'(r_hi), 64'(vecs[i].ehi));
            check($sformatf("v%0d_lo", i), 64'(r_lo), 64'(vecs[i].elo));
            check($sformatf("v%0d_done_at", i), 64'(done_at), 64'd32);
            check($sformatf("v%0d_done_cnt", i), 64'(done_cnt), 64'd1);
            check($sformatf("v%0d_busy_cnt", i), 64'(busy_cnt), 64'd33);
            check($sformatf("v%0d_divzero", i), 64'(dz_cnt), 64'd0);
            check($sformatf("v%0d_hold", i), 64'(hold_err), 64'd0);
        end

        // Divide by zero: flag for one cycle, results untouched.
        start = 1'b1; DivOrM = 1'b1; a = 32'd5; b = 32'd0;
        @(negedge clk);
        start = 1'b0;
        check("dz_pulse", 64'(DivZero), 64'h1);
        check("dz_done_low", 64'(done), 64'h0);
        dz = 0; dn = 0;
        for (int m = 1; m < 6; m++) begin
            @(negedge clk);
            if (DivZero) dz++;
            if (done) dn++;
            if (m == 1) check("dz_busy_low", 64'(busy), 64'h0);
        end
        check("dz_one_cycle", 64'(dz), 64'h0);
        check("dz_no_done", 64'(dn), 64'h0);
        check("dz_hi_kept", 64'(hi), 64'(vecs[c_NVEC-1].ehi));
        check("dz_lo_kept", 64'(lo), 64'(vecs[c_NVEC-1].elo));

        // start held high: back-to-back ops every 34 cycles, a/b scrambled while busy.
        start = 1'b1; DivOrM = 1'b0; a = 32'd3; b = 32'd4;
        prev = -1; dc = 0;
        for (int m = 0; m < 102; m++) begin
            @(negedge clk);
            if (done) begin
                dc++;
                check($sformatf("held_hi_%0d", dc), 64'(hi), 64'h0);
                check($sformatf("held_lo_%0d", dc), 64'(lo), 64'd12);
                if (prev >= 0) check($sformatf("held_gap_%0d", dc), 64'(m - prev), 64'd34);
                else check("held_first", 64'(m), 64'd32);
                prev = m;
            end
            if (m == 101) start = 1'b0;
            else if (busy) begin a = $urandom; b = $urandom; end
            else begin a = 32'd3; b = 32'd4; end
        end
        check("held_done_count", 64'(dc), 64'd3);

        // Reset asserted at iteration 10 of a multiply aborts it.
        start = 1'b1; DivOrM = 1'b0; a = 32'hFFFF_FFFB; b = 32'd6;
        @(negedge clk);
        start = 1'b0;
        repeat (9) @(negedge clk);
        reset = 1'b0;
        @(negedge clk);
        reset = 1'b1;
        check("abort_hi", 64'(hi), 64'h0);
        check("abort_lo", 64'(lo), 64'h0);
        check("abort_busy", 64'(busy), 64'h0);
        check("abort_done", 64'(done), 64'h0);
        check("abort_divzero", 64'(DivZero), 64'h0);
        dn = 0;
        for (int m = 0; m < 40; m++) begin
            @(negedge clk);
            if (done) dn++;
        end
        check("abort_no_done", 64'(dn), 64'h0);
        run_op(1'b0, 32'hFFFF_FFFB, 32'd6, r_hi, r_lo,
               done_at, done_cnt, busy_cnt, dz_cnt, hold_err);
        check("after_abort_hi", 64'(r_hi), 64'hFFFF_FFFF);
        check("after_abort_lo", 64'(r_lo), 64'hFFFF_FFE2);
        check("after_abort_done_at", 64'(done_at), 64'd32);
        check("after_abort_done_cnt", 64'(done_cnt), 64'd1);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/mult_div_unit.md
MULT_DIV_UNIT -- requirements
Module: mult_div_unit

Interface
REQ-001 The block SHALL use one clock; reset is synchronous and active-low.
REQ-002 clk  input  1  system clock; all state changes on the rising edge.
REQ-003 reset  input  1  synchronous active-low reset; reset=0 at a rising edge clears the block.
REQ-004 start  input  1  operation request from the control unit; sampled only in IDLE.
REQ-005 DivOrM  input  1  operation select: 1 = signed divide, 0 = signed multiply; sampled with start.
REQ-006 a  input  32  operand A (multiplicand / dividend); sampled with start.
REQ-007 b  input  32  operand B (multiplier / divisor); sampled with start.
REQ-008 hi  output  32  registered result: upper product word, or remainder.
REQ-009 lo  output  32  registered result: lower product word, or quotient.
REQ-010 busy  output  1  high in CALC and DONE, low in IDLE.
REQ-011 done  output  1  one-cycle pulse; hi/lo are valid and stable while it is high.
REQ-012 DivZero  output  1  one-cycle pulse flagging a divide with b=0.

Function
REQ-013 The FSM SHALL have exactly the states IDLE, CALC, DONE and ZERO.
REQ-014 IDLE with start=1 at edge k: latch a, b and DivOrM, clear the 6-bit iteration counter, and go to CALC.
REQ-015 IDLE with start=1, DivOrM=1 and b=0 at edge k: go to ZERO instead of CALC and leave hi/lo unchanged.
REQ-016 ZERO SHALL assert DivZero=1 for exactly one cycle, then go to IDLE with done=0 throughout.
REQ-017 CALC SHALL perform one shift-add (multiply) or one restoring-division step (divide) per cycle on absolute values.
REQ-018 After 32 iterations (edge k+32), the final hi/lo SHALL be written and the state SHALL become DONE.
REQ-019 done SHALL be high for exactly the one cycle between edges k+32 and k+33, then the state returns to IDLE.
REQ-020 Latency from the start-sampling edge to the done cycle SHALL be fixed at 32 cycles, independent of operand values.
REQ-021 Multiply: {hi,lo} SHALL be the exact signed 64-bit product of a and b; no overflow is possible.
REQ-022 Divide: lo SHALL be the signed quotient truncated toward zero.
REQ-023 Divide: hi SHALL be the remainder; its sign follows the dividend, and a = lo*b + hi holds.
REQ-024 Divide 0x80000000 / 0xFFFFFFFF SHALL give lo=0x80000000 and hi=0 (wrap), with no flag.
REQ-025 start asserted in CALC, DONE or ZERO SHALL be ignored; it is not queued.
REQ-026 A start in the same cycle as done SHALL be ignored; a new start is accepted from the next IDLE cycle.
REQ-027 hi/lo SHALL change only at the DONE-entry edge; they hold their previous result during CALC.
REQ-028 a, b and DivOrM changing after the sampling edge SHALL NOT affect the running operation.

Reset
REQ-029 reset=0 at any edge SHALL force: state=IDLE, iteration counter=0, hi=0, lo=0, busy=0, done=0, DivZero=0.
REQ-030 reset=0 SHALL override start at the same edge.
REQ-031 reset=0 mid-CALC SHALL abort the operation with no done pulse; the next start after release begins a full 32-cycle operation.

Verification
REQ-032 Multiply: a=7, b=0xFFFFFFFD, DivOrM=0, start at edge k -> done only in cycle k+32..k+33, hi=0xFFFFFFFF, lo=0xFFFFFFEB, busy high for 33 cycles.
REQ-033 Divide: a=0xFFFFFFF9 (-7), b=2, DivOrM=1 -> lo=0xFFFFFFFD, hi=0xFFFFFFFF, done one cycle.
REQ-034 Divide by zero: a=5, b=0, DivOrM=1 -> DivZero high one cycle after the start edge, done never high, hi/lo retain prior values, busy low again after 2 cycles.
REQ-035 Edge cases: 0x80000000/0xFFFFFFFF -> lo=0x80000000, hi=0; multiply 0x80000000*0x80000000 -> hi=0x40000000, lo=0.
REQ-036 start held high continuously for 100 cycles with a=3, b=4, DivOrM=0 -> one operation per 34 cycles (IDLE, 32 CALC, DONE), each giving lo=12, hi=0; toggling a/b during CALC does not change the result.
REQ-037 reset=0 for one edge at iteration 10 of a multiply -> all outputs 0, no done pulse; a new start gives a correct result 32 cycles later.
